// File: rtl/basket_display_controller.sv
// basket_display_controller
//   Owns the sale-terminal basket and hover cursor. It applies debounced
//   button commands to a working copy of the basket and compacts the basket
//   after a removal from the middle. It copies the working copy to the
//   display-facing outputs only at frame start, so a frame never shows a
//   half-updated basket.
//
// Ports
//   CLOCK                  pixel clock (only clock)
//   RESET                  synchronous, active-high
//   FrameStart             one-cycle pulse at the top-left pixel
//   SW2                    hover mode: 0 = product grid, 1 = basket slots
//   BTN_NEXT/PREV/ADD/REMOVE/CLEAR  one-cycle command pulses
//   HighlightedProductList visible one-hot hover mask
//   BasketProductNum       visible filled-slot count
//   BasketProductIDList    visible slot IDs, slot i at [i*ID_WIDTH +: ID_WIDTH]
//   BasketFull/BasketEmpty registered flags of the working count
//   Busy                   compacting or a snapshot is waiting for a frame
//   CmdError               one-cycle pulse per rejected command
//
// Build option
//   BASKET_DUP_CHECK_EN    reject ADD of an ID already in the basket
module basket_display_controller #(
   parameter int SLOTS     = 12,
   parameter int ID_WIDTH  = 4,
   parameter int CNT_WIDTH = 4
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic                         FrameStart,
   input  logic                         SW2,
   input  logic                         BTN_NEXT,
   input  logic                         BTN_PREV,
   input  logic                         BTN_ADD,
   input  logic                         BTN_REMOVE,
   input  logic                         BTN_CLEAR,
   output logic [SLOTS-1:0]             HighlightedProductList,
   output logic [CNT_WIDTH-1:0]         BasketProductNum,
   output logic [SLOTS*ID_WIDTH-1:0]    BasketProductIDList,
   output logic                         BasketFull,
   output logic                         BasketEmpty,
   output logic                         Busy,
   output logic                         CmdError
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUBLISH} state_t;
   typedef logic [SLOTS-1:0][ID_WIDTH-1:0] list_t;

   localparam logic [ID_WIDTH-1:0]  EMPTY_ID = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SLOTS);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SLOTS - 1);
   localparam logic [SLOTS-1:0]     HL_ONE   = SLOTS'(1);

   state_t                 state, state_nxt;
   list_t                  wlist, wlist_nxt, vlist, vlist_nxt;
   logic [CNT_WIDTH-1:0]   wcnt, wcnt_nxt, vcnt, vcnt_nxt;
   logic [CNT_WIDTH-1:0]   cursor, cursor_nxt, sidx, sidx_nxt;
   logic [SLOTS-1:0]       vhl, vhl_nxt, hl_w;
   logic                   pending, pending_nxt;
   logic                   sw2_q, full_q, empty_q, err_q, err_nxt;
   logic                   cmd_any, accept, dup;
   logic [ID_WIDTH-1:0]    cur_id;

   assign cmd_any = BTN_NEXT | BTN_PREV | BTN_ADD | BTN_REMOVE | BTN_CLEAR;
   // In grid mode the cursor position is the product ID.
   assign cur_id  = ID_WIDTH'(cursor);
   // In basket mode an empty basket has nothing to hover.
   assign hl_w    = (SW2 && wcnt == '0) ? '0 : (HL_ONE << cursor);

`ifdef BASKET_DUP_CHECK_EN
   // The basket is always compact in IDLE, so slots below the count are
   // exactly the occupied ones.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < SLOTS; i++)
         if (CNT_WIDTH'(i) < wcnt && wlist[i] == cur_id) dup = 1'b1;
   end
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      wlist_nxt   = wlist;
      wcnt_nxt    = wcnt;
      cursor_nxt  = cursor;
      sidx_nxt    = sidx;
      pending_nxt = pending;
      vlist_nxt   = vlist;
      vcnt_nxt    = vcnt;
      vhl_nxt     = vhl;
      err_nxt     = 1'b0;
      accept      = 1'b0;

      if (state == S_SHIFT) begin
         err_nxt = cmd_any;
         if (sidx < wcnt - CNT_ONE) begin
            // Pull the next slot down; the slot above is refilled on the
            // following step or stays empty when it was the last one.
            wlist_nxt[sidx]           = wlist[sidx + CNT_ONE];
            wlist_nxt[sidx + CNT_ONE] = EMPTY_ID;
            sidx_nxt                  = sidx + CNT_ONE;
         end else begin
            wcnt_nxt = wcnt - CNT_ONE;
            if (cursor >= wcnt_nxt)
               cursor_nxt = (wcnt_nxt == '0) ? '0 : wcnt_nxt - CNT_ONE;
            state_nxt = S_IDLE;
         end
      end else begin
         if (state == S_PUBLISH) begin
            // Snapshot of pre-command state; a command in this cycle just
            // re-arms pending for the next frame.
            vlist_nxt   = wlist;
            vcnt_nxt    = wcnt;
            vhl_nxt     = hl_w;
            pending_nxt = 1'b0;
            state_nxt   = S_IDLE;
         end
         if (BTN_CLEAR) begin
            wlist_nxt  = {SLOTS{EMPTY_ID}};
            wcnt_nxt   = '0;
            cursor_nxt = '0;
            accept     = 1'b1;
         end else if (BTN_REMOVE) begin
            if (wcnt == '0 || (SW2 && cursor >= wcnt)) begin
               err_nxt = 1'b1;
            end else if (!SW2) begin
               wlist_nxt[wcnt - CNT_ONE] = EMPTY_ID;
               wcnt_nxt                  = wcnt - CNT_ONE;
               accept                    = 1'b1;
            end else begin
               wlist_nxt[cursor] = EMPTY_ID;
               sidx_nxt          = cursor;
               state_nxt         = S_SHIFT;
               accept            = 1'b1;
            end
         end else if (BTN_ADD) begin
            if (SW2 || wcnt == CNT_FULL || dup) begin
               err_nxt = 1'b1;
            end else begin
               wlist_nxt[wcnt] = cur_id;
               wcnt_nxt        = wcnt + CNT_ONE;
               accept          = 1'b1;
            end
         end else if (BTN_NEXT) begin
            accept = 1'b1;
            if (!SW2)
               cursor_nxt = (cursor >= CNT_LAST) ? '0 : cursor + CNT_ONE;
            else if (wcnt == '0)
               cursor_nxt = '0;
            else
               cursor_nxt = (cursor >= wcnt - CNT_ONE) ? '0 : cursor + CNT_ONE;
         end else if (BTN_PREV) begin
            accept = 1'b1;
            if (!SW2)
               cursor_nxt = (cursor == '0) ? CNT_LAST : cursor - CNT_ONE;
            else if (wcnt == '0)
               cursor_nxt = '0;
            else
               cursor_nxt = (cursor == '0 || cursor >= wcnt) ? wcnt - CNT_ONE
                                                              : cursor - CNT_ONE;
         end
         if (accept) pending_nxt = 1'b1;
      end

      // Mode switch rehomes the cursor and changes the mask meaning.
      if (SW2 != sw2_q) begin
         cursor_nxt  = '0;
         pending_nxt = 1'b1;
      end

      // Decided last so a coincident command or mode switch is included.
      if (state == S_IDLE && state_nxt == S_IDLE && FrameStart && pending_nxt)
         state_nxt = S_PUBLISH;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= S_IDLE;
         wlist   <= {SLOTS{EMPTY_ID}};
         vlist   <= {SLOTS{EMPTY_ID}};
         wcnt    <= '0;
         vcnt    <= '0;
         cursor  <= '0;
         sidx    <= '0;
         vhl     <= '0;
         pending <= 1'b0;
         sw2_q   <= SW2;   // no phantom mode edge when reset releases
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         wlist   <= wlist_nxt;
         vlist   <= vlist_nxt;
         wcnt    <= wcnt_nxt;
         vcnt    <= vcnt_nxt;
         cursor  <= cursor_nxt;
         sidx    <= sidx_nxt;
         vhl     <= vhl_nxt;
         pending <= pending_nxt;
         sw2_q   <= SW2;
         full_q  <= (wcnt_nxt == CNT_FULL);
         empty_q <= (wcnt_nxt == '0);
         err_q   <= err_nxt;
      end
   end

   assign HighlightedProductList = vhl;
   assign BasketProductNum       = vcnt;
   assign BasketProductIDList    = vlist;
   assign BasketFull             = full_q;
   assign BasketEmpty            = empty_q;
   assign Busy                   = (state == S_SHIFT) || pending;
   assign CmdError               = err_q;

endmodule

// File: tb/tb_basket_display_controller.sv
// Directed bench for basket_display_controller. Stimulus pushes expected
// values tagged with the cycle they must hold in; a monitor pops and compares
// at the falling edge of that cycle.
module tb_basket_display_controller;
   localparam int SLOTS = 12, IDW = 4, CW = 4;
   localparam int K_CNT = 0, K_IDS = 1, K_HL = 2, K_FULL = 3, K_EMPTY = 4,
                  K_BUSY = 5, K_ERR = 6;
   // {clear, remove, add, next, prev}
   localparam logic [4:0] C_CLR = 5'b10000, C_REM = 5'b01000, C_ADD = 5'b00100,
                          C_NXT = 5'b00010, C_PRV = 5'b00001;
   localparam logic [47:0] ALL_F = 48'hFFFF_FFFF_FFFF;
`ifdef BASKET_DUP_CHECK_EN
   localparam bit DUP = 1'b1;
`else
   localparam bit DUP = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1, fs = 1'b0, sw2 = 1'b0;
   logic bn = 1'b0, bp = 1'b0, ba = 1'b0, br = 1'b0, bc = 1'b0;
   logic [SLOTS-1:0]     hl;
   logic [CW-1:0]        cnt;
   logic [SLOTS*IDW-1:0] ids;
   logic                 full, empty, busy, err;

   basket_display_controller dut (
      .CLOCK(clk), .RESET(rst), .FrameStart(fs), .SW2(sw2),
      .BTN_NEXT(bn), .BTN_PREV(bp), .BTN_ADD(ba), .BTN_REMOVE(br), .BTN_CLEAR(bc),
      .HighlightedProductList(hl), .BasketProductNum(cnt), .BasketProductIDList(ids),
      .BasketFull(full), .BasketEmpty(empty), .Busy(busy), .CmdError(err)
   );

   typedef struct {
      int          due;
      string       name;
      int          kind;
      logic [47:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0, n_total = 0, n_pass = 0;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   function automatic logic [47:0] actual(int k);
      case (k)
         K_CNT:   return 48'(cnt);
         K_IDS:   return 48'(ids);
         K_HL:    return 48'(hl);
         K_FULL:  return 48'(full);
         K_EMPTY: return 48'(empty);
         K_BUSY:  return 48'(busy);
         default: return 48'(err);
      endcase
   endfunction

   initial begin
      exp_t        e;
      logic [47:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            n_total++;
            if (e.due != cyc)
               $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
            else if (act !== e.exp)
               $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.exp);
            else
               n_pass++;
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmd(logic [4:0] m);
      {bc, br, ba, bn, bp} = m;
      step();
      {bc, br, ba, bn, bp} = '0;
   endtask

   task automatic frame();
      fs = 1'b1;
      step();
      fs = 1'b0;
   endtask

   task automatic chk(string nm, int k, logic [47:0] v);
      sb.push_back('{cyc, nm, k, v});
   endtask

   task automatic chk_reset(string p);
      chk({p, "_cnt"},   K_CNT,   48'd0);
      chk({p, "_ids"},   K_IDS,   ALL_F);
      chk({p, "_hl"},    K_HL,    48'd0);
      chk({p, "_full"},  K_FULL,  48'd0);
      chk({p, "_empty"}, K_EMPTY, 48'd1);
      chk({p, "_busy"},  K_BUSY,  48'd0);
      chk({p, "_err"},   K_ERR,   48'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset values
      step(2);
      chk_reset("rst");
      rst = 1'b0;
      step();

      // Three ADDs at cursor 0/1/2, snapshot only after FrameStart
      cmd(C_ADD); cmd(C_NXT); cmd(C_ADD); cmd(C_NXT); cmd(C_ADD);
      chk("pre_frame_cnt", K_CNT, 48'd0);
      chk("pre_frame_busy", K_BUSY, 48'd1);
      chk("work_empty", K_EMPTY, 48'd0);
      frame();
      chk("publish_wait_cnt", K_CNT, 48'd0);
      step();
      chk("t1_cnt", K_CNT, 48'd3);
      chk("t1_ids", K_IDS, 48'hFFFF_FFFF_F210);
      chk("t1_hl", K_HL, 48'h004);
      chk("t1_busy", K_BUSY, 48'd0);

      // Fill all 12 slots, 13th ADD rejected
      cmd(C_CLR);
      for (int i = 0; i < SLOTS; i++) begin
         cmd(C_ADD);
         if (i == SLOTS - 1) begin
            chk("full_set", K_FULL, 48'd1);
            chk("last_add_ok", K_ERR, 48'd0);
         end
         cmd(C_NXT);
      end
      cmd(C_ADD);
      chk("overflow_err", K_ERR, 48'd1);
      chk("overflow_full", K_FULL, 48'd1);
      step();
      chk("err_one_cycle", K_ERR, 48'd0);
      frame(); step();
      chk("full_cnt", K_CNT, 48'd12);
      chk("full_ids", K_IDS, 48'hBA98_7654_3210);

      // Basket-mode remove from the middle with compaction
      cmd(C_CLR);
      cmd(C_ADD); cmd(C_NXT); cmd(C_ADD); cmd(C_NXT); cmd(C_ADD); cmd(C_NXT); cmd(C_ADD);
      sw2 = 1'b1; step();
      cmd(C_NXT);
      frame(); step();
      chk("t3_cnt", K_CNT, 48'd4);
      chk("t3_ids", K_IDS, 48'hFFFF_FFFF_3210);
      chk("t3_hl", K_HL, 48'h002);
      cmd(C_REM);
      chk("shift_busy", K_BUSY, 48'd1);
      chk("remove_ok", K_ERR, 48'd0);
      cmd(C_NXT);
      chk("mid_shift_err", K_ERR, 48'd1);
      frame();
      chk("shift_err_drop", K_ERR, 48'd0);
      chk("shift_busy2", K_BUSY, 48'd1);
      step(2);
      chk("deferred_cnt", K_CNT, 48'd4);
      chk("deferred_busy", K_BUSY, 48'd1);
      frame(); step();
      chk("compact_cnt", K_CNT, 48'd3);
      chk("compact_ids", K_IDS, 48'hFFFF_FFFF_F320);
      chk("compact_hl", K_HL, 48'h002);
      chk("compact_busy", K_BUSY, 48'd0);

      // Grid-mode PREV wrap, then CLEAR beats ADD
      sw2 = 1'b0; step();
      cmd(C_PRV);
      frame(); step();
      chk("wrap_hl", K_HL, 48'h800);
      cmd(C_CLR | C_ADD);
      chk("clr_prio_err", K_ERR, 48'd0);
      chk("clr_prio_empty", K_EMPTY, 48'd1);
      frame(); step();
      chk("clr_cnt", K_CNT, 48'd0);
      chk("clr_ids", K_IDS, ALL_F);
      chk("clr_hl", K_HL, 48'h001);

      // Reset in the middle of a shift
      cmd(C_ADD); cmd(C_NXT); cmd(C_ADD); cmd(C_NXT); cmd(C_ADD);
      frame(); step();
      chk("t5_cnt", K_CNT, 48'd3);
      sw2 = 1'b1; step();
      cmd(C_REM);
      chk("t5_shift_busy", K_BUSY, 48'd1);
      rst = 1'b1; step();
      chk_reset("midshift_rst");
      rst = 1'b0; step();
      chk("post_rst_busy", K_BUSY, 48'd0);
      chk("post_rst_empty", K_EMPTY, 48'd1);

      // Same product added twice
      sw2 = 1'b0; step();
      repeat (5) cmd(C_NXT);
      cmd(C_ADD);
      chk("dup_first_ok", K_ERR, 48'd0);
      cmd(C_ADD);
      chk("dup_second_err", K_ERR, DUP ? 48'd1 : 48'd0);
      frame(); step();
      chk("dup_cnt", K_CNT, DUP ? 48'd1 : 48'd2);
      chk("dup_ids", K_IDS, DUP ? 48'hFFFF_FFFF_FFF5 : 48'hFFFF_FFFF_FF55);

      // Let the monitor drain, bounded
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d checks never evaluated, want 0", sb.size());
         n_total += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
